// File: rtl/led_sequencer_if.sv
// Bundle between the config/stimulus side and the LED sequencer: table writes,
// sequence control, blinker feedback and the blinker drive outputs.
interface led_sequencer_if #(
  parameter int STEPS    = 4,
  parameter int PERIOD_W = 32,
  parameter int COUNT_W  = 8
);
  localparam int ADDR_W = $clog2(STEPS);

  logic                cfg_we;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [PERIOD_W-1:0] cfg_period;
  logic [COUNT_W-1:0]  cfg_count;
  logic                start;
  logic                stop;
  logic                loop;
  logic                led_in;
  logic [PERIOD_W-1:0] blink_period;
  logic                blink_reset;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   step;

  modport master (
    output cfg_we, cfg_addr, cfg_period, cfg_count, start, stop, loop, led_in,
    input  blink_period, blink_reset, busy, done, step
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_period, cfg_count, start, stop, loop, led_in,
    output blink_period, blink_reset, busy, done, step
  );
endinterface

// File: rtl/led_sequencer.sv
// Steps an external LED blinker through a table of {period, toggle count}
// entries, pulsing its reset between steps and counting its led toggles.
module led_sequencer #(
  parameter int STEPS    = 4,
  parameter int PERIOD_W = 32,
  parameter int COUNT_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  led_sequencer_if.slave  bus
);
  localparam int ADDR_W = $clog2(STEPS);
  localparam logic [ADDR_W-1:0] FIRST_IDX = '0;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   step_q, step_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic                led_prev_q, led_prev_d;

  logic [PERIOD_W-1:0] tbl_period_q [STEPS];
  logic [COUNT_W-1:0]  tbl_count_q  [STEPS];

  logic [ADDR_W-1:0]   nxt_idx_s;
  logic                seq_end_s;
  logic                step_end_s;
  logic [COUNT_W-1:0]  cnt_inc_s;

  // Look-ahead at the following entry to decide whether this step is the last one.
  always_comb begin
    nxt_idx_s = step_q + ADDR_W'(1);
    cnt_inc_s = cnt_q + COUNT_W'(1);
    if (step_q == LAST_IDX) begin
      seq_end_s = 1'b1;
    end else begin
      seq_end_s = (tbl_period_q[nxt_idx_s] == '0);
    end
  end

  // Next-state logic; period is loaded on entry to LOAD so the blinker sees it during its reset.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    led_prev_d = led_prev_q;
    step_end_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          step_d = FIRST_IDX;
          if (tbl_period_q[FIRST_IDX] != '0) begin
            state_d  = S_LOAD;
            period_d = tbl_period_q[FIRST_IDX];
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        // Sampling here hides the blinker's reset-to-0 transition from the edge detector.
        led_prev_d = bus.led_in;
        if (tbl_count_q[step_q] == '0) begin
          step_end_s = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        led_prev_d = bus.led_in;
        if (bus.led_in != led_prev_q) begin
          cnt_d      = cnt_inc_s;
          step_end_s = (cnt_inc_s == tbl_count_q[step_q]);
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        step_d  = FIRST_IDX;
      end
      default: begin
        state_d = S_IDLE;
        step_d  = FIRST_IDX;
      end
    endcase

    if (step_end_s) begin
      if (!seq_end_s) begin
        state_d  = S_LOAD;
        step_d   = nxt_idx_s;
        period_d = tbl_period_q[nxt_idx_s];
      end else if (bus.loop) begin
        state_d  = S_LOAD;
        step_d   = FIRST_IDX;
        period_d = tbl_period_q[FIRST_IDX];
      end else begin
        state_d = S_DONE;
      end
    end else begin
      state_d = state_d;
    end

    if (bus.stop) begin
      state_d = S_IDLE;
      step_d  = FIRST_IDX;
    end else begin
      step_d = step_d;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      period_q   <= '0;
      cnt_q      <= '0;
      led_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      led_prev_q <= led_prev_d;
    end
  end

  // Step table; writes land only while idle so a running sequence sees stable entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STEPS; i++) begin
        tbl_period_q[i] <= '0;
        tbl_count_q[i]  <= '0;
      end
    end else if (bus.cfg_we && (state_q == S_IDLE) && (int'(bus.cfg_addr) < STEPS)) begin
      tbl_period_q[bus.cfg_addr] <= bus.cfg_period;
      tbl_count_q[bus.cfg_addr]  <= bus.cfg_count;
    end
  end

  assign bus.blink_period = period_q;
  assign bus.blink_reset  = (state_q != S_SETTLE) && (state_q != S_RUN);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.step         = step_q;

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Sequences a downstream LED blinker through a programmable table of blink steps. Each step holds a blink period and a toggle count. The block drives the blinker's `period` and `reset` inputs and watches its `led` output to count toggles. It sits between a register/config master and a single blinker instance, and replaces hand-driven period/reset sequencing.

## Interface
Parameters:
- `STEPS`, 4: number of table entries (2..16).
- `PERIOD_W`, 32: width of a step period, matching the blinker `period` port.
- `COUNT_W`, 8: width of a step toggle count.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `cfg_we`, in, 1: table write strobe. Honoured only when `busy`=0.
- `cfg_addr`, in, $clog2(STEPS): table index to write.
- `cfg_period`, in, PERIOD_W: period written to the entry.
- `cfg_count`, in, COUNT_W: toggle count written to the entry.
- `start`, in, 1: one-cycle pulse that starts a sequence from step 0. Ignored when `busy`=1.
- `stop`, in, 1: aborts the sequence.
- `loop`, in, 1: sampled at the end of each sequence. When 1, the sequence restarts at step 0 instead of finishing.
- `led_in`, in, 1: the blinker's `led` output.
- `blink_period`, out, PERIOD_W: drives the blinker `period`.
- `blink_reset`, out, 1: drives the blinker `reset`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a sequence completes without `stop`.
- `step`, out, $clog2(STEPS): index of the active step.

## Operation
- Table: STEPS entries of {period, count}, all zero after reset.
  - A period of 0 marks end-of-sequence.
  - A count of 0 means the step is skipped after its LOAD and SETTLE cycles.
- State machine: IDLE, LOAD, SETTLE, RUN, DONE.
- IDLE
  - `blink_reset`=1 and `blink_period` holds its last value.
  - `start` with entry 0 period ≠ 0 goes to LOAD with `step`=0.
  - `start` with entry 0 period = 0 goes to DONE.
- LOAD (1 cycle)
  - `blink_period` <= table[step].period.
  - `blink_reset`=1.
  - Toggle counter cleared. Go to SETTLE.
- SETTLE (1 cycle)
  - `blink_reset`=0.
  - `led_prev` <= `led_in`. Edges are not counted in this cycle, which absorbs the blinker's reset-to-0 transition.
  - Go to RUN. If count = 0, the step ends here instead, using the step-end rule below.
- RUN
  - Every cycle, `led_prev` <= `led_in`.
  - A cycle where `led_in` ≠ `led_prev` increments the toggle counter (COUNT_W bits).
  - The cycle in which the increment makes the counter equal the step count ends the step.
- Step end
  - Next index = step+1.
  - If next index = STEPS, or table[next].period = 0, the sequence ends.
    - With `loop`=1: go to LOAD at step 0.
    - With `loop`=0: go to DONE.
  - Otherwise go to LOAD at the next index.
- DONE (1 cycle): `done`=1, then IDLE with `step`=0.
- `stop` in any state goes to IDLE on the next edge with no `done`. `stop` wins over `start` and over step end.
- `cfg_we` while `busy`=1 is dropped, so table contents are stable during a run.

## Timing
- Reset values: `blink_period`=0, `blink_reset`=1, `busy`=0, `done`=0, `step`=0, state IDLE.
- All outputs are registered or decoded from the state register. There are no combinational paths from any input to any output.
- Latency from the `start` edge:
  - LOAD in cycle +1.
  - SETTLE in cycle +2.
  - First countable edge in cycle +3.
- Step-to-step gap: 2 cycles (LOAD and SETTLE), during which `blink_reset` is high for exactly 1 cycle.
- With the blinker toggling every P cycles, a step with count N occupies 2 + N·P cycles, ±1 for edge registration.
- `done` rises on the cycle after the final step's last counted toggle, and `busy` falls one cycle after that.
- Reset asserted mid-run forces the reset values on the next edge regardless of state, and clears the table.

## Test plan
- Reset, then write {5,4} to entry 0, leave entry 1 period = 0, pulse `start`:
  - `blink_period`=5 from cycle +1.
  - `blink_reset` high only in cycle +1.
  - Exactly 4 toggles counted.
  - `done` fires once, `busy` falls.
- Table {1,6},{3,2},{7,1},{2,3}, `start`, `loop`=0:
  - `step` goes 0,1,2,3.
  - `blink_period` goes 1,3,7,2.
  - Each step change has a 2-cycle gap.
  - A single `done` after step 3's third toggle.
- Entry 1 count = 0, entry 2 = {4,2}: step 1 lasts LOAD+SETTLE only, then step 2 runs for 2 toggles.
- `loop`=1 with table {2,2}:
  - `step` returns to 0, no `done` is seen for 3 iterations.
  - Pulse `stop`: IDLE next edge, `blink_reset`=1, `done` stays 0.
- While `busy`, `cfg_we` writes entry 0 with {9,9}: after the run, entry 0 still holds its original value. Same cycle `start`+`stop` from IDLE: stays IDLE.
- `reset` asserted during RUN of step 2: next edge shows all reset values. A following `start` with an unprogrammed table gives DONE then IDLE (entry 0 period = 0).
